// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access widths, dump FSM states, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam logic LOW   = 1'b0;
  localparam logic HIGH  = 1'b1;
  localparam logic CLEAR = 1'b0;

  localparam int DEFAULT_DATA_MEMORY_ADDR_SIZE = 8;

  // Access width codes; 2'b11 is reserved and behaves as a word access.
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_READ = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_DONE = 2'd3
  } dump_state_t;

  // Halfwords must sit on an even byte, words (and reserved) on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
    case (width)
      MEM_BYTE: return LOW;
      MEM_HALF: return lane[0];
      default:  return (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory with per-byte write enables and a dedicated dump read port.
// Latency: async read on the pipeline port, one cycle on the dump port; writes land at the edge.
// Backpressure: none; the caller gates write enables and dump reads.
module mem_stage_data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_W/8-1:0]   i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_W-1:0]     o_rdata,
  input  logic                  i_dump_re,
  input  logic [ADDR_W-1:0]     i_dump_addr,
  output logic [DATA_W-1:0]     o_dump_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dump_rdata_q;

  // Reset clears every word; otherwise only the enabled byte lanes are updated.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int b = 0; b < LANES; b++) begin
        if (i_we[b]) begin
          mem_q[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read port used only by the dump engine.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dump_rdata_q <= '0;
    end else if (i_dump_re) begin
      dump_rdata_q <= mem_q[i_dump_addr];
    end
  end

  // Pipeline loads see the pre-edge contents, so same-cycle RAW returns old data.
  assign o_rdata      = mem_q[i_raddr];
  assign o_dump_rdata = dump_rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: byte/half/word stores, extended async loads, post-halt memory dump engine.
// Latency: loads are combinational; stores commit at the edge; dump delivers a word every 2 cycles.
// Backpressure: dump word held with valid until ready; pipeline stores are dropped while dumping.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_SIZE      = 32,
  parameter int MEM_ADDR_SIZE = DEFAULT_DATA_MEMORY_ADDR_SIZE
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_mem_rd,
  input  logic                     i_mem_wr,
  input  logic [1:0]               i_mem_width,
  input  logic                     i_unsigned,
  input  logic [BUS_SIZE-1:0]      i_addr,
  input  logic [BUS_SIZE-1:0]      i_data_wr,
  output logic [BUS_SIZE-1:0]      o_mem_result,
  output logic                     o_misaligned,
  output logic                     o_mem_error,
  input  logic                     i_dump_start,
  input  logic                     i_dump_ready,
  output logic                     o_dump_valid,
  output logic [MEM_ADDR_SIZE-1:0] o_dump_addr,
  output logic [BUS_SIZE-1:0]      o_dump_data,
  output logic                     o_dump_busy,
  output logic                     o_dump_done
);

  localparam int LANES = BUS_SIZE / 8;
  localparam logic [LANES-1:0] ONE_LANE  = LANES'(1);
  localparam logic [LANES-1:0] TWO_LANES = LANES'(3);

  logic [MEM_ADDR_SIZE-1:0] word_idx;
  logic [1:0]               lane;
  logic                     misaligned;
  logic                     store_en;
  logic [LANES-1:0]         lane_we;
  logic [LANES-1:0]         mem_we;
  logic [BUS_SIZE-1:0]      mem_wdata;
  logic [BUS_SIZE-1:0]      rd_word;
  logic [BUS_SIZE-1:0]      rd_shift;
  logic                     ext_bit;
  logic                     unused_addr_bits;

  logic                     mem_error_q;
  dump_state_t              state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] ptr_q, ptr_d;
  logic [MEM_ADDR_SIZE-1:0] dump_addr_q, dump_addr_d;
  logic                     dump_re;

  // Address bits above the word index are ignored, so the memory aliases across the space.
  assign word_idx         = i_addr[MEM_ADDR_SIZE+1:2];
  assign lane             = i_addr[1:0];
  assign unused_addr_bits = ^i_addr[BUS_SIZE-1:MEM_ADDR_SIZE+2];

  assign misaligned   = is_misaligned(i_mem_width, lane);
  assign o_misaligned = (i_mem_rd | i_mem_wr) & misaligned;
  assign o_dump_busy  = (state_q != DUMP_IDLE);
  assign store_en     = i_enable & i_mem_wr & ~misaligned & ~o_dump_busy;
  assign mem_we       = store_en ? lane_we : '0;

  // Replicate the low store bytes across the word and pick the addressed lanes.
  always_comb begin
    lane_we   = '1;
    mem_wdata = i_data_wr;
    case (i_mem_width)
      MEM_BYTE: begin
        lane_we   = ONE_LANE << lane;
        mem_wdata = {LANES{i_data_wr[7:0]}};
      end
      MEM_HALF: begin
        lane_we   = TWO_LANES << {lane[1], 1'b0};
        mem_wdata = {(LANES/2){i_data_wr[15:0]}};
      end
      default: begin
        lane_we   = '1;
        mem_wdata = i_data_wr;
      end
    endcase
  end

  mem_stage_data_memory #(
    .DATA_W (BUS_SIZE),
    .ADDR_W (MEM_ADDR_SIZE)
  ) u_data_memory (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_we         (mem_we),
    .i_waddr      (word_idx),
    .i_wdata      (mem_wdata),
    .i_raddr      (word_idx),
    .o_rdata      (rd_word),
    .i_dump_re    (dump_re),
    .i_dump_addr  (ptr_q),
    .o_dump_rdata (o_dump_data)
  );

  // Shift the addressed lane down to bit 0, then sign- or zero-extend per width.
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    o_mem_result = '0;
    ext_bit      = LOW;
    if (i_mem_rd && !misaligned) begin
      case (i_mem_width)
        MEM_BYTE: begin
          ext_bit      = ~i_unsigned & rd_shift[7];
          o_mem_result = {{(BUS_SIZE-8){ext_bit}}, rd_shift[7:0]};
        end
        MEM_HALF: begin
          ext_bit      = ~i_unsigned & rd_shift[15];
          o_mem_result = {{(BUS_SIZE-16){ext_bit}}, rd_shift[15:0]};
        end
        default: o_mem_result = rd_shift;
      endcase
    end
  end

  // Sticky error: any enabled misaligned access latches until reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_error_q <= CLEAR;
    end else if (o_misaligned && i_enable) begin
      mem_error_q <= HIGH;
    end
  end

  assign o_mem_error = mem_error_q;

  // Dump FSM state, pointer and reported address registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= DUMP_IDLE;
      ptr_q       <= '0;
      dump_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dump_addr_q <= dump_addr_d;
    end
  end

  // Dump next-state: read a word, offer it until accepted, step to the next or finish.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    dump_addr_d  = dump_addr_q;
    dump_re      = LOW;
    o_dump_valid = LOW;
    o_dump_done  = LOW;
    case (state_q)
      DUMP_IDLE: begin
        if (i_dump_start) begin
          ptr_d   = '0;
          state_d = DUMP_READ;
        end
      end
      DUMP_READ: begin
        dump_re     = HIGH;
        dump_addr_d = ptr_q;
        state_d     = DUMP_SEND;
      end
      DUMP_SEND: begin
        o_dump_valid = HIGH;
        if (i_dump_ready) begin
          if (ptr_q == '1) begin
            state_d = DUMP_DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = DUMP_READ;
          end
        end
      end
      DUMP_DONE: begin
        o_dump_done = HIGH;
        state_d     = DUMP_IDLE;
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  assign o_dump_addr = dump_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized accesses against a byte-level model.
// Latency: loads checked in the same cycle, stores and error flag checked after the edge.
// Backpressure: dump consumer ready is randomized to exercise holding of stalled words.
module tb_mem_stage;

  logic        i_clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_mem_rd;
  logic        i_mem_wr;
  logic [1:0]  i_mem_width;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_data_wr;
  logic [31:0] o_mem_result;
  logic        o_misaligned;
  logic        o_mem_error;
  logic        i_dump_start;
  logic        i_dump_ready;
  logic        o_dump_valid;
  logic [7:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_dump_busy;
  logic        o_dump_done;

  mem_stage #(.BUS_SIZE(32), .MEM_ADDR_SIZE(8)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_mem_rd     (i_mem_rd),
    .i_mem_wr     (i_mem_wr),
    .i_mem_width  (i_mem_width),
    .i_unsigned   (i_unsigned),
    .i_addr       (i_addr),
    .i_data_wr    (i_data_wr),
    .o_mem_result (o_mem_result),
    .o_misaligned (o_misaligned),
    .o_mem_error  (o_mem_error),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_dump_valid (o_dump_valid),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_busy  (o_dump_busy),
    .o_dump_done  (o_dump_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [31:0] model_mem [256];
  bit          model_err;
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_mis(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'd0) return 1'b0;
    if (w == 2'd1) return a[0];
    return (a[1:0] != 2'd0);
  endfunction

  // Load value from plain arithmetic on the stored word.
  function automatic logic [31:0] ref_load(input bit rd, input logic [1:0] w, input bit uns,
                                           input logic [31:0] a);
    logic [31:0] sh;
    logic [31:0] v;
    if (!rd || ref_mis(w, a)) return 32'd0;
    sh = model_mem[a[9:2]] >> (8 * a[1:0]);
    if (w == 2'd0) begin
      v = sh & 32'h0000_00FF;
      return (!uns && v >= 32'd128) ? v - 32'd256 : v;
    end
    if (w == 2'd1) begin
      v = sh & 32'h0000_FFFF;
      return (!uns && v >= 32'd32768) ? v - 32'd65536 : v;
    end
    return sh;
  endfunction

  task automatic ref_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    int n;
    int base;
    n    = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    base = (w >= 2'd2) ? 0 : int'(a[1:0]);
    for (int k = 0; k < n; k++) begin
      model_mem[a[9:2]][8*(base+k) +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    model_err = 1'b0;
  endtask

  // One pipeline access: drive, check combinational outputs mid-cycle, then advance the model.
  task automatic op(input bit rd, input bit wr, input bit en, input logic [1:0] w, input bit uns,
                    input logic [31:0] a, input logic [31:0] d, input string tag);
    bit mis;
    i_mem_rd    = rd;
    i_mem_wr    = wr;
    i_enable    = en;
    i_mem_width = w;
    i_unsigned  = uns;
    i_addr      = a;
    i_data_wr   = d;
    mis         = (rd || wr) && ref_mis(w, a);
    @(negedge i_clk);
    check_eq({tag, " result"}, o_mem_result, ref_load(rd, w, uns, a));
    check_eq({tag, " misaligned"}, 32'(o_misaligned), 32'(mis));
    check_eq({tag, " mem_error"}, 32'(o_mem_error), 32'(model_err));
    @(posedge i_clk);
    if (en && wr && !ref_mis(w, a)) ref_store(w, a, d);
    if (en && mis) model_err = 1'b1;
    #1;
  endtask

  task automatic quiet();
    i_mem_rd     = 1'b0;
    i_mem_wr     = 1'b0;
    i_enable     = 1'b0;
    i_dump_start = 1'b0;
    i_dump_ready = 1'b0;
  endtask

  initial begin
    int          exp_idx;
    int          done_cnt;
    int          cycles;
    bit          fin;
    bit          stalled;
    logic [31:0] prev_d;
    logic [7:0]  prev_a;
    logic [31:0] ra;

    n_checks    = 0;
    n_fail      = 0;
    i_reset     = 1'b1;
    i_mem_width = 2'd0;
    i_unsigned  = 1'b0;
    i_addr      = 32'd0;
    i_data_wr   = 32'd0;
    quiet();
    clear_model();
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;

    @(negedge i_clk);
    check_eq("rst dump_valid", 32'(o_dump_valid), 32'd0);
    check_eq("rst dump_addr", 32'(o_dump_addr), 32'd0);
    check_eq("rst dump_data", o_dump_data, 32'd0);
    check_eq("rst dump_busy", 32'(o_dump_busy), 32'd0);
    check_eq("rst dump_done", 32'(o_dump_done), 32'd0);
    check_eq("rst mem_error", 32'(o_mem_error), 32'd0);
    @(posedge i_clk);
    #1;

    // Word store with same-cycle load (old data), then the new data.
    op(1, 1, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, "t1 raw");
    op(1, 0, 1, 2'd2, 0, 32'h10, 32'h0, "t1 load");
    check_eq("t1 const", o_mem_result, 32'hDEADBEEF);

    // Byte store and extended loads.
    op(0, 1, 1, 2'd0, 0, 32'h11, 32'h0000_0080, "t2 sb");
    op(1, 0, 1, 2'd0, 0, 32'h11, 32'h0, "t2 lb");
    op(1, 0, 1, 2'd0, 1, 32'h11, 32'h0, "t2 lbu");
    op(1, 0, 1, 2'd2, 0, 32'h10, 32'h0, "t2 lw");
    op(1, 0, 1, 2'd1, 0, 32'h12, 32'h0, "t2 lh");
    op(1, 0, 1, 2'd1, 1, 32'h12, 32'h0, "t2 lhu");

    // Disabled store, then a store through an aliased high address.
    op(0, 1, 0, 2'd2, 0, 32'h20, 32'h12345678, "t4 en0");
    op(1, 0, 1, 2'd2, 0, 32'h20, 32'h0, "t4 en0 load");
    op(0, 1, 1, 2'd2, 0, 32'hABCD_0C20, 32'h12345678, "t4 wrap");
    op(1, 0, 1, 2'd2, 0, 32'h20, 32'h0, "t4 wrap load");
    op(0, 1, 1, 2'd1, 0, 32'h22, 32'h0000_A5C3, "t4 sh");
    op(1, 0, 1, 2'd2, 0, 32'h20, 32'h0, "t4 sh load");

    // Misaligned store and load.
    op(0, 1, 1, 2'd1, 0, 32'h13, 32'h0000_BEEF, "t3 sh mis");
    op(1, 0, 1, 2'd2, 0, 32'h10, 32'h0, "t3 unchanged");
    op(1, 0, 1, 2'd2, 0, 32'h12, 32'h0, "t3 lw mis");
    check_eq("t3 err sticky", 32'(o_mem_error), 32'd1);

    // Randomized accesses over a handful of words with random upper address bits.
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom << 10) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      op(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 4 != 0), 2'($urandom % 4),
         1'($urandom % 2), ra, $urandom, "rand");
    end

    // Dump: words 0..3 = 1..4, random ready, blocked stores and stray starts while busy.
    for (int i = 0; i < 4; i++) op(0, 1, 1, 2'd2, 0, 32'(i * 4), 32'(i + 1), "t5 fill");
    quiet();
    i_dump_start = 1'b1;
    @(posedge i_clk);
    #1 i_dump_start = 1'b0;
    exp_idx  = 0;
    done_cnt = 0;
    cycles   = 0;
    fin      = 1'b0;
    stalled  = 1'b0;
    prev_d   = 32'd0;
    prev_a   = 8'd0;
    while (!fin && cycles < 3000) begin
      i_dump_ready = 1'($urandom % 2);
      i_dump_start = 1'($urandom % 16 == 0);
      i_mem_wr     = 1'b1;
      i_enable     = 1'b1;
      i_mem_width  = 2'd2;
      i_addr       = 32'h0;
      i_data_wr    = $urandom;
      @(negedge i_clk);
      check_eq("dump busy", 32'(o_dump_busy), 32'd1);
      if (stalled) begin
        check_eq("dump hold valid", 32'(o_dump_valid), 32'd1);
        check_eq("dump hold data", o_dump_data, prev_d);
        check_eq("dump hold addr", 32'(o_dump_addr), 32'(prev_a));
      end
      if (o_dump_valid && i_dump_ready) begin
        check_eq("dump addr", 32'(o_dump_addr), 32'(exp_idx));
        check_eq("dump data", o_dump_data, model_mem[exp_idx[7:0]]);
        exp_idx++;
      end
      stalled = o_dump_valid && !i_dump_ready;
      prev_d  = o_dump_data;
      prev_a  = o_dump_addr;
      if (o_dump_done) begin
        done_cnt++;
        check_eq("dump count at done", 32'(exp_idx), 32'd256);
        fin = 1'b1;
      end
      @(posedge i_clk);
      #1;
      cycles++;
    end
    if (!fin) check_eq("dump timeout", 32'd0, 32'd1);
    quiet();
    @(negedge i_clk);
    check_eq("dump done pulse", 32'(o_dump_done), 32'd0);
    check_eq("dump idle busy", 32'(o_dump_busy), 32'd0);
    check_eq("dump done count", 32'(done_cnt), 32'd1);
    @(posedge i_clk);
    #1;
    op(1, 0, 1, 2'd2, 0, 32'h0, 32'h0, "t5 word0 kept");
    check_eq("t5 word0 const", o_mem_result, 32'd1);
    quiet();

    // Reset during SEND aborts the dump and clears memory.
    i_dump_start = 1'b1;
    @(posedge i_clk);
    #1 i_dump_start = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 10 && !fin; c++) begin
      @(negedge i_clk);
      if (o_dump_valid) fin = 1'b1;
    end
    if (!fin) check_eq("t6 valid timeout", 32'd0, 32'd1);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    clear_model();
    @(negedge i_clk);
    check_eq("t6 dump_valid", 32'(o_dump_valid), 32'd0);
    check_eq("t6 dump_busy", 32'(o_dump_busy), 32'd0);
    check_eq("t6 dump_done", 32'(o_dump_done), 32'd0);
    check_eq("t6 dump_addr", 32'(o_dump_addr), 32'd0);
    check_eq("t6 dump_data", o_dump_data, 32'd0);
    check_eq("t6 mem_error", 32'(o_mem_error), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check_eq("t6 no done", 32'(o_dump_done), 32'd0);
    end
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 6; i++) op(1, 0, 1, 2'd2, 0, 32'(i * 4), 32'h0, "t6 cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
